// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared constants and helpers for the mcpu_core slice.
//   - OP_*  : 2-bit opcodes of the load/store ISA.
//   - ST_*  : 3-bit FSM state encoding, also driven onto the debug LEDs.
//   - sext  : sign-extends the low w bits of a value to 64 bits; callers
//             slice the result down to DATA_W or PC_W.
package mcpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;

  // w is the width of the field held in the low bits of v (1..64).
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    logic [5:0]  msb;
    msb  = 6'(w - 1);
    mask = ~64'd0 << w;
    if (v[msb]) sext = v | mask;
    else        sext = v & ~mask;
  endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// mcpu_regfile: NREG x DATA_W register file.
// Ports:
//   Clk, Reset      - rising-edge clock, asynchronous active-high reset (clears all)
//   ra_a/ra_b       - read addresses; rd_a/rd_b are combinational read data
//   we, wa, wd      - synchronous write port
module mcpu_regfile
  import mcpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [REG_AW-1:0] ra_a,
  input  logic [REG_AW-1:0] ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd_a = regs[ra_a];
  assign rd_b = regs[ra_b];

endmodule

// File: rtl/mcpu_core.sv
// mcpu_core: multi-cycle load/store CPU core (IDLE/FETCH/DECODE/EXEC/MEM/WB).
// Ports:
//   Clk, Reset            - rising-edge clock, asynchronous active-high reset
//   step_en               - starts the next instruction when in IDLE
//   imem_addr/imem_rdata  - instruction ROM (combinational read of pc)
//   dmem_*                - data RAM request/acknowledge interface
//   pc                    - current program counter
//   wb_valid/wb_reg/wb_data - register write-back observation
//   state_o, opcode_o     - debug view of FSM state and latched opcode
// Build option: define MCPU_BEQ_EN to turn op 11 into BEQ (branch only when
// R[rs] == R[rt]); otherwise op 11 is an unconditional JMP.
//
// Data-memory handshake: dmem_req is high exactly while in MEM; dmem_addr,
// dmem_we and dmem_wdata are held stable for the whole request. A request
// completes on the rising edge where dmem_ack = 1 (possibly the first MEM
// cycle); load data is taken from dmem_rdata on that edge. dmem_ack is
// ignored outside MEM. dmem_req is decoded from the state register, so
// Reset drops it without waiting for a clock edge.
module mcpu_core
  import mcpu_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REG_AW  = 2,
  parameter  int PC_W    = 8,
  localparam int INSTR_W = 2 + 3 * REG_AW
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               step_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [PC_W-1:0]    dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [PC_W-1:0]    pc,
  output logic               wb_valid,
  output logic [REG_AW-1:0]  wb_reg,
  output logic [DATA_W-1:0]  wb_data,
  output logic [2:0]         state_o,
  output logic [1:0]         opcode_o
);

  logic [2:0]         state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  opa_q, opb_q, result_q;
  logic [PC_W-1:0]    addr_q;

  // Instruction fields
  logic [1:0]        op;
  logic [REG_AW-1:0] rs, rt, rd;
  assign op = instr_q[INSTR_W-1 -: 2];
  assign rs = instr_q[3*REG_AW-1 -: REG_AW];
  assign rt = instr_q[2*REG_AW-1 -: REG_AW];
  assign rd = instr_q[REG_AW-1:0];

  logic [63:0]       imm_ext;
  logic [DATA_W-1:0] addr_sum;
  logic [PC_W-1:0]   addr_pc, pc_plus1, jmp_target;
  logic              take_jump;

  assign imm_ext    = sext({{(64-REG_AW){1'b0}}, rd}, REG_AW);
  assign addr_sum   = opa_q + imm_ext[DATA_W-1:0];
  assign pc_plus1   = pc_q + PC_W'(1);
  assign jmp_target = pc_plus1 + imm_ext[PC_W-1:0];

  // Effective address is formed in DATA_W bits, then fitted to PC_W.
  if (PC_W > DATA_W) begin : g_addr_zext
    assign addr_pc = {{(PC_W-DATA_W){1'b0}}, addr_sum};
  end else begin : g_addr_trunc
    assign addr_pc = addr_sum[PC_W-1:0];
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, imm_ext, addr_sum};

`ifdef MCPU_BEQ_EN
  assign take_jump = (opa_q == opb_q);
`else
  assign take_jump = 1'b1;
`endif

  // Register file
  logic [DATA_W-1:0] rf_a, rf_b;
  logic              rf_we;
  logic [REG_AW-1:0] rf_wa;

  assign rf_we = (state_q == ST_WB) && ((op == OP_ADD) || (op == OP_LW));
  assign rf_wa = (op == OP_LW) ? rt : rd;

  mcpu_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .Clk   (Clk),
    .Reset (Reset),
    .ra_a  (rs),
    .ra_b  (rt),
    .rd_a  (rf_a),
    .rd_b  (rf_b),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (result_q)
  );

  // Sequencer
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      addr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (step_en) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          instr_q <= imem_rdata;
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          opa_q   <= rf_a;
          opb_q   <= rf_b;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          case (op)
            OP_ADD: begin
              result_q <= opa_q + opb_q;
              state_q  <= ST_WB;
            end
            OP_LW, OP_SW: begin
              addr_q  <= addr_pc;
              state_q <= ST_MEM;
            end
            default: state_q <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (op == OP_LW) result_q <= dmem_rdata;
            state_q <= ST_WB;
          end
        end
        ST_WB: begin
          pc_q    <= ((op == OP_JMP) && take_jump) ? jmp_target : pc_plus1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign dmem_req   = (state_q == ST_MEM);
  assign dmem_we    = dmem_req && (op == OP_SW);
  assign dmem_addr  = addr_q;
  assign dmem_wdata = opb_q;
  assign wb_valid   = rf_we;
  assign wb_reg     = rf_wa;
  assign wb_data    = result_q;
  assign state_o    = state_q;
  assign opcode_o   = op;

endmodule

// File: tb/tb_mcpu_core.sv
// tb_mcpu_core: self-checking bench for mcpu_core (default parameters).
// The reference model holds architectural state (registers, pc) as plain
// arrays and computes each instruction's effect with integer arithmetic.
module tb_mcpu_core;

  localparam int S_IDLE = 0;
  localparam int S_EXEC = 3;
  localparam int S_WB   = 5;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       step_en = 1'b0;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       dmem_req, dmem_we;
  logic [7:0] dmem_addr, dmem_wdata;
  logic [7:0] dmem_rdata = 8'h00;
  logic       dmem_ack = 1'b0;
  logic [7:0] pc;
  logic       wb_valid;
  logic [1:0] wb_reg;
  logic [7:0] wb_data;
  logic [2:0] state_o;
  logic [1:0] opcode_o;

  mcpu_core dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .step_en    (step_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .pc         (pc),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .state_o    (state_o),
    .opcode_o   (opcode_o)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- memories and model state ----------------
  logic [7:0] rom [256];
  logic [7:0] ram [256];
  assign imem_rdata = rom[imem_addr];

  logic [7:0] m_reg [4];
  logic [7:0] m_pc;
  logic [9:0] exp_q [$];   // {reg, data} of expected write-backs

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_pc = 8'h00;
    exp_q.delete();
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    step_en  = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  // Executes one instruction from IDLE and checks it against the model.
  // Entered and left at a falling edge with the core in IDLE.
  task automatic run_instr(input int delay, input bit tied, input bit pulse, input bit stray);
    logic [7:0] ins, exp_addr, exp_wdata, nxt_pc, wb_val;
    logic [9:0] e;
    int op, rs, rt, rd, s, n, reqc, waitc, exp_lat;
    bit exp_req, exp_we, do_wb, taken;
    chk("idle_entry", 32'(state_o), S_IDLE);
    chk("pc", 32'(pc), 32'(m_pc));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    ins = rom[m_pc];
    op = int'(ins[7:6]); rs = int'(ins[5:4]); rt = int'(ins[3:2]); rd = int'(ins[1:0]);
    s = (rd >= 2) ? rd - 4 : rd;
    nxt_pc = m_pc + 8'd1;
    exp_req = 0; exp_we = 0; do_wb = 0; exp_lat = 5;
    exp_addr = 8'h00; exp_wdata = 8'h00; wb_val = 8'h00;
    case (op)
      0: begin
        wb_val = 8'((int'(m_reg[rs]) + int'(m_reg[rt])) % 256);
        do_wb = 1;
        exp_q.push_back({2'(rd), wb_val});
      end
      1: begin
        exp_addr = 8'((int'(m_reg[rs]) + s) & 255);
        exp_req = 1; exp_lat = 6 + delay;
        wb_val = ram[exp_addr];
        do_wb = 1;
        exp_q.push_back({2'(rt), wb_val});
      end
      2: begin
        exp_addr = 8'((int'(m_reg[rs]) + s) & 255);
        exp_wdata = m_reg[rt];
        exp_req = 1; exp_we = 1; exp_lat = 6 + delay;
      end
      default: begin
`ifdef MCPU_BEQ_EN
        taken = (m_reg[rs] == m_reg[rt]);
`else
        taken = 1;
`endif
        if (taken) nxt_pc = 8'((int'(m_pc) + 1 + s) & 255);
      end
    endcase

    step_en = 1'b1;
    @(posedge Clk);
    n = 1; reqc = 0; waitc = 0;
    if (!tied) #1 step_en = 1'b0;
    forever begin
      @(negedge Clk);
      if (int'(state_o) == S_IDLE) break;
      if (!tied) step_en = pulse && (int'(state_o) == S_EXEC);
      if (int'(state_o) == S_WB) chk("opcode", 32'(opcode_o), 32'(op));
      if (wb_valid) begin
        if (exp_q.size() == 0) chk("wb_spurious", 32'(1), 32'(0));
        else begin
          e = exp_q.pop_front();
          chk("wb_reg", 32'(wb_reg), 32'(e[9:8]));
          chk("wb_data", 32'(wb_data), 32'(e[7:0]));
        end
      end
      dmem_ack = 1'b0;
      if (dmem_req) begin
        reqc++;
        chk("dmem_req_expected", 32'(dmem_req), 32'(exp_req));
        chk("dmem_addr", 32'(dmem_addr), 32'(exp_addr));
        chk("dmem_we", 32'(dmem_we), 32'(exp_we));
        if (exp_we) chk("dmem_wdata", 32'(dmem_wdata), 32'(exp_wdata));
        if (waitc == delay) begin
          dmem_ack = 1'b1;
          if (dmem_we) ram[dmem_addr] = dmem_wdata;
          else         dmem_rdata = ram[dmem_addr];
        end else begin
          waitc++;
          dmem_rdata = 8'($urandom);
        end
      end else begin
        dmem_ack   = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        dmem_rdata = 8'($urandom);
      end
      if (n >= 60) begin
        chk("timeout_cycles", 32'(n), 32'(exp_lat));
        break;
      end
      @(posedge Clk);
      n++;
    end
    dmem_ack = 1'b0;
    if (!tied) step_en = 1'b0;
    chk("latency", 32'(n), 32'(exp_lat));
    chk("req_cycles", 32'(reqc), exp_req ? 32'(delay + 1) : 32'(0));
    chk("wb_missing", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    chk("pc_next", 32'(pc), 32'(nxt_pc));
    if (exp_we) chk("ram_written", 32'(ram[exp_addr]), 32'(exp_wdata));
    m_pc = nxt_pc;
    if (do_wb) m_reg[(op == 1) ? rt : rd] = wb_val;
    if (pulse && !tied) begin
      @(posedge Clk);
      @(negedge Clk);
      chk("step_ignored", 32'(state_o), S_IDLE);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    bit tied;
    for (int i = 0; i < 256; i++) begin rom[i] = 8'h00; ram[i] = 8'h00; end
    rom[0] = 8'h45;   // LW  r1, 1(r0)
    rom[1] = 8'h16;   // ADD r2 = r1 + r1
    rom[2] = 8'h9B;   // SW  r2, -1(r1)
`ifdef MCPU_BEQ_EN
    rom[3] = 8'hC6;   // BEQ r0, r1, -2
`else
    rom[3] = 8'hC2;   // JMP -2
`endif
    rom[4] = 8'h9B;
    ram[1] = 8'h05;

    do_reset();
    chk("rst_state", 32'(state_o), S_IDLE);
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_imem_addr", 32'(imem_addr), 32'(0));
    chk("rst_dmem_req", 32'(dmem_req), 32'(0));
    chk("rst_dmem_we", 32'(dmem_we), 32'(0));
    chk("rst_dmem_addr", 32'(dmem_addr), 32'(0));
    chk("rst_dmem_wdata", 32'(dmem_wdata), 32'(0));
    chk("rst_wb_valid", 32'(wb_valid), 32'(0));
    chk("rst_wb_reg", 32'(wb_reg), 32'(0));
    chk("rst_wb_data", 32'(wb_data), 32'(0));
    chk("rst_opcode", 32'(opcode_o), 32'(0));

    // Directed program
    run_instr(0, 0, 0, 0);
    run_instr(0, 0, 0, 0);
    run_instr(3, 0, 0, 0);
    run_instr(0, 0, 0, 0);
    chk("dir_ram4", 32'(ram[4]), 32'(8'h0A));
`ifdef MCPU_BEQ_EN
    chk("dir_branch_pc", 32'(pc), 32'(4));
`else
    chk("dir_branch_pc", 32'(pc), 32'(2));
`endif

    // Reset while a store is waiting for its acknowledge
    step_en = 1'b1;
    @(posedge Clk);
    #1 step_en = 1'b0;
    k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!dmem_req && k < 10);
    chk("mid_reach_mem", 32'(dmem_req), 32'(1));
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'(0));
    chk("mid_rst_we", 32'(dmem_we), 32'(0));
    chk("mid_rst_state", 32'(state_o), S_IDLE);
    chk("mid_rst_pc", 32'(pc), 32'(0));
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    rom[0] = 8'h16;   // r1 + r1 must read back as zero after reset
    run_instr(0, 0, 0, 0);

    // Data and pc wrap with step_en tied high
    do_reset();
    rom[0] = 8'h45;   // LW r1, 1(r0)   -> 0x01
    rom[1] = 8'h4B;   // LW r2, -1(r0)  -> 0xFF
    for (int i = 2; i < 255; i++) rom[i] = 8'h00;
    rom[255] = 8'h1B; // ADD r3 = r1 + r2 at pc 0xFF
    ram[1] = 8'h01;
    ram[255] = 8'hFF;
    for (int i = 0; i < 256; i++) run_instr(0, 1, 0, 0);
    step_en = 1'b0;
    chk("wrap_pc", 32'(pc), 32'(0));

    // Randomized program
    do_reset();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom);
      ram[i] = 8'($urandom);
    end
    for (int i = 0; i < 300; i++) begin
      tied = ($urandom_range(0, 3) == 0);
      run_instr(int'($urandom_range(0, 3)), tied,
                !tied && ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    end
    step_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mcpu_core.md
Name: mcpu_core

Overview:
- Parametrised multi-cycle load/store CPU core and the next generation of the board-level 8-bit teaching processor.
- Register width, register count and PC width are parametrised; the 4-opcode ISA and field layout carry over.
- An explicit FSM sequences each instruction. It adds a stall-capable data-memory req/ack handshake and a step-enable input, so a slow tick (e.g. 1 Hz divider) or free-running operation is possible.
- Sits between an external instruction ROM, an external data RAM and the 7-segment/LED debug outputs.

Parameters:
- DATA_W, 8, register/ALU/data-memory word width.
- REG_AW, 2, register-address width; NREG = 2**REG_AW; immediate width = REG_AW.
- PC_W, 8, program counter width; also data-memory address width.
- INSTR_W, derived = 2 + 3*REG_AW; not user-overridable.

Ports:
- Clk, in, 1, rising-edge clock.
- Reset, in, 1, asynchronous, active-high.
- step_en, in, 1, one-cycle pulse (or tie high) that starts the next instruction from IDLE.
- imem_addr, out, PC_W, equals pc.
- imem_rdata, in, INSTR_W, combinational ROM data for imem_addr.
- dmem_req, out, 1, data-memory request.
- dmem_we, out, 1, 1 = write, 0 = read; valid while dmem_req.
- dmem_addr, out, PC_W, data-memory address.
- dmem_wdata, out, DATA_W, store data.
- dmem_rdata, in, DATA_W, load data; valid in the dmem_ack cycle.
- dmem_ack, in, 1, completes a request.
- pc, out, PC_W, current PC.
- wb_valid, out, 1, one-cycle pulse in WB when a register is written.
- wb_reg, out, REG_AW, destination register.
- wb_data, out, DATA_W, value written.
- state_o, out, 3, FSM state for debug LEDs.
- opcode_o, out, 2, latched opcode.

Behaviour:
- ISA, instr fields: [INSTR_W-1:INSTR_W-2] op, then rs, then rt, then rd/imm (REG_AW bits each). imm is sign-extended to DATA_W.
  - op 00 ADD: R[rd] = R[rs] + R[rt], modulo 2**DATA_W.
  - op 01 LW: R[rt] = M[R[rs] + sext(imm)].
  - op 10 SW: M[R[rs] + sext(imm)] = R[rt].
  - op 11 JMP: pc = pc + 1 + sext(imm).
- Address arithmetic: computed in DATA_W bits, then truncated or zero-extended to PC_W. PC arithmetic wraps modulo 2**PC_W.
- Reset:
  - state = IDLE, pc = 0, all registers = 0, instruction latch = 0.
  - dmem_req = 0, dmem_we = 0, wb_valid = 0, all other outputs 0.
  - Asserting Reset mid-instruction aborts it immediately. dmem_req drops asynchronously and no register or PC update occurs.
- FSM, one state per rising edge unless stated:
  - IDLE: waits for step_en = 1, then goes to FETCH.
  - FETCH: latch imem_rdata, go to DECODE.
  - DECODE: latch R[rs] and R[rt] into operand registers, go to EXEC.
  - EXEC: compute ALU result or address. LW/SW go to MEM; ADD/JMP go to WB.
  - MEM: dmem_req = 1 with stable addr/we/wdata until an edge where dmem_ack = 1.
    - Ack may arrive in the first MEM cycle; stall is unbounded.
    - On ack, LW captures dmem_rdata; the state goes to WB and dmem_req is 0 in WB.
    - dmem_ack outside MEM is ignored.
  - WB: ADD/LW write the register; wb_valid = 1 for this cycle only. pc updates to pc+1, or the jump target for JMP. Go to IDLE.
- Latency with zero-wait ack: ADD/JMP take 5 cycles from the step_en edge (FETCH..WB + return to IDLE); LW/SW take 6.
- step_en pulses outside IDLE are ignored, not queued. step_en tied high gives back-to-back execution.
- Register 0 is an ordinary writable register.
- A write and a read of the same register never overlap, because of the multi-cycle sequencing. No bypass is needed.
- An unused state encoding returns to IDLE on the next edge with no side effects.

Optional Feature:
- Macro MCPU_BEQ_EN.
  - Defined: op 11 is BEQ. The branch to pc + 1 + sext(imm) is taken only if R[rs] == R[rt]; otherwise pc + 1.
  - Undefined: op 11 is an unconditional JMP and rs/rt are ignored.
- Latency is identical in both builds.

Decomposition:
- Package mcpu_pkg holds:
  - opcode constants OP_ADD/OP_LW/OP_SW/OP_JMP;
  - the 3-bit state encoding ST_IDLE..ST_WB;
  - a sign-extend function parameterised by REG_AW/DATA_W.
- Sub-module mcpu_regfile:
  - NREG x DATA_W;
  - two asynchronous read ports and one synchronous write port;
  - asynchronous Reset to zero.
- The FSM, ALU and PC logic stay in mcpu_core.

Test Plan (defaults, dmem model preloaded M[1] = 0x05, ack after 0 waits unless stated):
- Reset mid-MEM with dmem_req = 1: dmem_req falls asynchronously, pc = 0, state_o = IDLE, registers are 0.
- pc 0, instr 0x45 (LW r1, 1(r0)), step_en pulse: dmem_addr = 0x01 with we = 0; at WB wb_reg = 1, wb_data = 0x05; pc = 1 after 6 cycles.
- pc 1, instr 0x16 (ADD r2 = r1 + r1): wb_valid pulse with wb_reg = 2, wb_data = 0x0A; pc = 2; no dmem_req.
- pc 2, instr 0x9B (SW r2, -1(r1)), ack delayed 3 cycles: dmem_req high 4 cycles with addr = 0x04, wdata = 0x0A, we = 1; no wb_valid; pc = 3.
- pc 3, instr 0xC2 (JMP -2): pc = 2 after WB. Build with MCPU_BEQ_EN, instr 0xC6 (BEQ r0, r1, -2; r0 = 0, r1 = 5): not taken, pc = 4.
- ADD with 0xFF + 0x01, step_en tied high: wb_data = 0x00 (wrap); pc = 0xFF then next pc = 0x00; step_en pulses during EXEC are ignored.
